// File: rtl/i2c_pkg.sv
// Shared I2C definitions: transfer direction, acknowledge levels and target states.
package i2c_pkg;

  localparam logic I2C_MODE_WRITE = 1'b0;
  localparam logic I2C_MODE_READ  = 1'b1;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings scl/sda into the clk domain and flags scl edges and START/STOP line conditions.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Idle bus level is high, so reset to '1 to avoid false edges after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing an 8-bit register pointer/data interface to a register file.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       nack_seen
);

  i2c_state_e state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       byte_full, byte_full_nxt;
  logic [7:0] rx_sr, rx_nxt;
  logic [7:0] tx_sr, tx_nxt;
  logic       rw, rw_nxt;
  logic [7:0] addr_nxt, wdata_nxt;
  logic       we_nxt, busy_nxt, nack_nxt;
  logic       drive_low, drive_nxt;
  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic       rx_state;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl      (scl),
    .sda      (sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign sda      = drive_low ? 1'b0 : 1'bz;
  assign rx_state = (state == ST_ADDR) || (state == ST_PTR) || (state == ST_WDATA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      byte_full <= 1'b0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rw        <= I2C_MODE_WRITE;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      busy      <= 1'b0;
      nack_seen <= 1'b0;
      drive_low <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      byte_full <= byte_full_nxt;
      rx_sr     <= rx_nxt;
      tx_sr     <= tx_nxt;
      rw        <= rw_nxt;
      reg_addr  <= addr_nxt;
      reg_wdata <= wdata_nxt;
      reg_we    <= we_nxt;
      busy      <= busy_nxt;
      nack_seen <= nack_nxt;
      drive_low <= drive_nxt;
    end
  end

  // byte_full marks 8 received rises, so the scl fall that follows START is ignored.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    byte_full_nxt = byte_full;
    rx_nxt        = rx_sr;
    tx_nxt        = tx_sr;
    rw_nxt        = rw;
    addr_nxt      = reg_addr;
    wdata_nxt     = reg_wdata;
    we_nxt        = 1'b0;
    busy_nxt      = busy;
    nack_nxt      = 1'b0;
    drive_nxt     = drive_low;

    if (stop_det) begin
      state_nxt = ST_IDLE;
      drive_nxt = 1'b0;
      busy_nxt  = 1'b0;
    end else if (start_det) begin
      state_nxt     = ST_ADDR;
      bit_cnt_nxt   = '0;
      byte_full_nxt = 1'b0;
      drive_nxt     = 1'b0;
      busy_nxt      = 1'b0;
    end else begin
      if (scl_rise && rx_state) begin
        rx_nxt      = {rx_sr[6:0], sda_s};
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_full_nxt = 1'b1;
      end

      if (scl_rise && state == ST_RDATA_ACK) begin
        addr_nxt = reg_addr + 8'd1;
        if (sda_s == NACK) begin
          nack_nxt  = 1'b1;
          state_nxt = ST_WAIT_STOP;
        end
      end

      if (scl_fall) begin
        unique case (state)
          ST_ADDR: begin
            if (byte_full) begin
              byte_full_nxt = 1'b0;
              if (rx_sr[7:1] == SLAVE_ADDR) begin
                state_nxt = ST_ADDR_ACK;
                busy_nxt  = 1'b1;
                drive_nxt = 1'b1;
                rw_nxt    = rx_sr[0];
              end else begin
                state_nxt = ST_WAIT_STOP;
              end
            end
          end
          ST_ADDR_ACK, ST_RDATA_ACK: begin
            if (state == ST_RDATA_ACK || rw == I2C_MODE_READ) begin
              // tx_sr holds the bits still to send after the one now driven.
              tx_nxt      = {reg_rdata[6:0], 1'b0};
              drive_nxt   = ~reg_rdata[7];
              bit_cnt_nxt = '0;
              state_nxt   = ST_RDATA;
            end else begin
              drive_nxt     = 1'b0;
              bit_cnt_nxt   = '0;
              byte_full_nxt = 1'b0;
              state_nxt     = ST_PTR;
            end
          end
          ST_PTR: begin
            if (byte_full) begin
              byte_full_nxt = 1'b0;
              addr_nxt      = rx_sr;
              drive_nxt     = 1'b1;
              state_nxt     = ST_PTR_ACK;
            end
          end
          ST_PTR_ACK: begin
            drive_nxt = 1'b0;
            state_nxt = ST_WDATA;
          end
          ST_WDATA: begin
            if (byte_full) begin
              byte_full_nxt = 1'b0;
              wdata_nxt     = rx_sr;
              we_nxt        = 1'b1;
              drive_nxt     = 1'b1;
              state_nxt     = ST_WDATA_ACK;
            end
          end
          ST_WDATA_ACK: begin
            drive_nxt = 1'b0;
            addr_nxt  = reg_addr + 8'd1;
            state_nxt = ST_WDATA;
          end
          ST_RDATA: begin
            if (bit_cnt == 3'd7) begin
              drive_nxt   = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = ST_RDATA_ACK;
            end else begin
              drive_nxt   = ~tx_sr[7];
              tx_nxt      = {tx_sr[6:0], 1'b0};
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bus-functional master plus register-file model driving i2c_slave_regs with directed and random transfers.
module tb_i2c_slave_regs;
  import i2c_pkg::*;

  localparam logic [6:0] SLAVE_ADDR  = 7'h50;
  localparam int         SYNC_STAGES = 2;
  localparam int         Q           = 16;  // clks per quarter SCL period

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, busy, nack_seen;

  logic [7:0] regs [8];
  logic [7:0] mregs [8];
  logic       pre_we = 1'b0;
  logic [2:0] pre_idx = '0;
  logic [7:0] pre_val = '0;

  int          n_checks;
  int          n_fail;
  logic [7:0]  m_ptr;
  logic [7:0]  wq[$];
  logic [7:0]  rd_got[$];
  logic [15:0] exp_wr[$];
  logic [15:0] wr_log[$];
  int          exp_nack;
  logic        silent_txn;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  i2c_slave_regs #(.SLAVE_ADDR(SLAVE_ADDR), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl      (scl),
    .sda      (sda),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_rdata(reg_rdata),
    .busy     (busy),
    .nack_seen(nack_seen)
  );

  assign reg_rdata = regs[reg_addr[2:0]];
  always @(posedge clk) begin
    if (reg_we) regs[reg_addr[2:0]] <= reg_wdata;
    else if (pre_we) regs[pre_idx] <= pre_val;
  end

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, required %02h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  // Per-cycle compare of write strobes, NACK pulses and bus silence against the model.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (reg_we) begin
        wr_log.push_back({reg_addr, reg_wdata});
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_we: got write addr %02h data %02h, required none", reg_addr, reg_wdata);
        end else begin
          logic [15:0] e;
          e = exp_wr.pop_front();
          chk8("we_addr", reg_addr, e[15:8]);
          chk8("we_data", reg_wdata, e[7:0]);
        end
      end
      if (nack_seen) begin
        n_checks++;
        if (exp_nack == 0) begin
          n_fail++;
          $display("FAIL nack_seen: got pulse, required none");
        end else exp_nack--;
      end
      if (silent_txn && !m_low) chk1("sda_released", sda, 1'b1);
    end
  end

  task automatic wait_q(input int n);
    repeat (n * Q) @(posedge clk);
  endtask

  task automatic preload(input int idx, input logic [7:0] v);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = idx[2:0];
    pre_val = v;
    @(negedge clk);
    pre_we  = 1'b0;
    mregs[idx] = v;
  endtask

  task automatic m_start();
    m_low = 1'b0; wait_q(1);
    scl   = 1'b1; wait_q(1);
    m_low = 1'b1; wait_q(1);
    scl   = 1'b0; wait_q(1);
  endtask

  task automatic m_stop();
    m_low = 1'b1; wait_q(1);
    scl   = 1'b1; wait_q(1);
    m_low = 1'b0; wait_q(2);
  endtask

  task automatic m_send_bit(input logic b);
    m_low = ~b; wait_q(1);
    scl   = 1'b1; wait_q(1);
    if (b) chk1("bus_bit_high", sda, 1'b1);
    wait_q(1);
    scl   = 1'b0; wait_q(1);
  endtask

  task automatic m_recv_bit(output logic b);
    m_low = 1'b0; wait_q(1);
    scl   = 1'b1; wait_q(1);
    b     = sda;  wait_q(1);
    scl   = 1'b0; wait_q(1);
  endtask

  task automatic m_write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) m_send_bit(d[i]);
    m_recv_bit(ack);
  endtask

  task automatic m_read_byte(output logic [7:0] d, input logic ack_bit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      m_recv_bit(b);
      d[i] = b;
    end
    m_send_bit(ack_bit);
  endtask

  task automatic m_end();
    m_stop();
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk1("busy_after_stop", busy, 1'b0);
    chk8("ptr_after_stop", reg_addr, m_ptr);
  endtask

  // Write transfer: address, pointer, then the bytes queued in wq.
  task automatic txn_write(input logic [6:0] a7, input logic [7:0] ptr, input logic do_stop);
    logic ack, match;
    match = (a7 == SLAVE_ADDR);
    silent_txn = ~match;
    m_start();
    m_write_byte({a7, I2C_MODE_WRITE}, ack);
    chk1("addr_ack", ack, match ? ACK : NACK);
    chk1("busy_after_addr", busy, match);
    m_write_byte(ptr, ack);
    chk1("ptr_ack", ack, match ? ACK : NACK);
    if (match) m_ptr = ptr;
    foreach (wq[i]) begin
      if (match) begin
        exp_wr.push_back({m_ptr, wq[i]});
        mregs[m_ptr[2:0]] = wq[i];
      end
      m_write_byte(wq[i], ack);
      chk1("data_ack", ack, match ? ACK : NACK);
      if (match) m_ptr = m_ptr + 8'd1;
    end
    wq.delete();
    if (do_stop) m_end();
    silent_txn = 1'b0;
  endtask

  // Read transfer of n bytes from the current pointer, last byte NACKed.
  task automatic txn_read(input int n);
    logic ack;
    logic [7:0] d;
    m_start();
    m_write_byte({SLAVE_ADDR, I2C_MODE_READ}, ack);
    chk1("raddr_ack", ack, ACK);
    chk1("busy_read", busy, 1'b1);
    rd_got.delete();
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) exp_nack++;
      m_read_byte(d, (i == n - 1) ? NACK : ACK);
      chk8("rdata", d, mregs[m_ptr[2:0]]);
      rd_got.push_back(d);
      m_ptr = m_ptr + 8'd1;
    end
    m_end();
  endtask

  initial begin
    logic [15:0] e;
    logic [6:0]  a7;
    logic        ack;
    int          k;
    n_checks   = 0;
    n_fail     = 0;
    exp_nack   = 0;
    silent_txn = 1'b0;
    m_ptr      = '0;
    reset_n    = 1'b0;
    scl        = 1'b1;
    m_low      = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk1("rst_sda", sda, 1'b1);
    chk8("rst_reg_addr", reg_addr, 8'h00);
    chk8("rst_reg_wdata", reg_wdata, 8'h00);
    chk1("rst_reg_we", reg_we, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_nack_seen", nack_seen, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 8; i++) preload(i, 8'($urandom));

    // Write pointer 3 then two data bytes
    k = wr_log.size();
    wq.push_back(8'h5A);
    wq.push_back(8'hC3);
    txn_write(SLAVE_ADDR, 8'h03, 1'b1);
    e = wr_log[k];     chk8("t1_we0_addr", e[15:8], 8'h03); chk8("t1_we0_data", e[7:0], 8'h5A);
    e = wr_log[k + 1]; chk8("t1_we1_addr", e[15:8], 8'h04); chk8("t1_we1_data", e[7:0], 8'hC3);
    chk8("t1_ptr", reg_addr, 8'h05);

    // Pointer-only write, then a separate two-byte read
    preload(2, 8'h11);
    preload(3, 8'h22);
    txn_write(SLAVE_ADDR, 8'h02, 1'b1);
    txn_read(2);
    chk8("t2_byte0", rd_got[0], 8'h11);
    chk8("t2_byte1", rd_got[1], 8'h22);
    chk8("t2_ptr", reg_addr, 8'h04);

    // Foreign address stays silent; next transfer is served normally
    k = wr_log.size();
    wq.push_back(8'hDE);
    txn_write(7'h51, 8'h06, 1'b1);
    chk8("t3_no_we", 8'(wr_log.size() - k), 8'd0);
    wq.push_back(8'h44);
    txn_write(SLAVE_ADDR, 8'h06, 1'b1);

    // Pointer wrap from FF to 00
    k = wr_log.size();
    wq.push_back(8'hAA);
    wq.push_back(8'hBB);
    txn_write(SLAVE_ADDR, 8'hFF, 1'b1);
    e = wr_log[k];     chk8("t4_we0_addr", e[15:8], 8'hFF); chk8("t4_we0_data", e[7:0], 8'hAA);
    e = wr_log[k + 1]; chk8("t4_we1_addr", e[15:8], 8'h00); chk8("t4_we1_data", e[7:0], 8'hBB);
    chk8("t4_ptr", reg_addr, 8'h01);

    // Repeated START between pointer write and read
    preload(7, 8'h77);
    k = wr_log.size();
    txn_write(SLAVE_ADDR, 8'h07, 1'b0);
    txn_read(1);
    chk8("t5_byte", rd_got[0], 8'h77);
    chk8("t5_no_we", 8'(wr_log.size() - k), 8'd0);
    chk8("t5_ptr", reg_addr, 8'h08);

    // Random transfers
    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          repeat ($urandom_range(1, 3)) wq.push_back(8'($urandom));
          txn_write(SLAVE_ADDR, 8'($urandom), 1'b1);
        end
        1: txn_read(int'($urandom_range(1, 3)));
        2: begin
          txn_write(SLAVE_ADDR, 8'($urandom), 1'b0);
          txn_read(int'($urandom_range(1, 2)));
        end
        default: begin
          a7 = 7'($urandom_range(0, 127));
          if (a7 == SLAVE_ADDR) a7 = a7 ^ 7'h01;
          wq.push_back(8'($urandom));
          txn_write(a7, 8'($urandom), 1'b1);
        end
      endcase
    end

    // Reset while the target drives a 0 data bit
    preload(0, 8'h3C);
    txn_write(SLAVE_ADDR, 8'h00, 1'b1);
    m_start();
    m_write_byte({SLAVE_ADDR, I2C_MODE_READ}, ack);
    chk1("t6_addr_ack", ack, ACK);
    m_low = 1'b0; wait_q(1);
    scl   = 1'b1; wait_q(1);
    chk1("t6_sda_driven", sda, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk1("t6_sda_released", sda, 1'b1);
    chk1("t6_busy_reset", busy, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    m_ptr = '0;
    exp_wr.delete();
    exp_nack = 0;
    chk8("t6_ptr_reset", reg_addr, 8'h00);
    repeat (4) @(posedge clk);
    txn_read(1);
    chk8("t6_byte", rd_got[0], 8'h3C);

    repeat (20) @(posedge clk);
    chk8("pending_we", 8'(exp_wr.size()), 8'd0);
    chk8("pending_nack", 8'(exp_nack), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
